// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin peripheral-port arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Requester-side and downstream signals of the arbiter; slave = arbiter view, master = environment view.
interface bus_rr_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]         req_ss;
  logic [N_REQ-1:0]         req_we;
  logic [N_REQ-1:0][AW-1:0] req_addr;
  logic [N_REQ-1:0][DW-1:0] req_wdata;
  logic [N_REQ-1:0][DW-1:0] req_rdata;
  logic [N_REQ-1:0]         req_bdone;
  logic [N_REQ-1:0]         req_err;
  logic                     s_ss;
  logic                     s_we;
  logic [AW-1:0]            s_addr;
  logic [DW-1:0]            s_wdata;
  logic [DW-1:0]            s_rdata;
  logic                     s_bdone;

  modport slave (
    input  req_ss, req_we, req_addr, req_wdata, s_rdata, s_bdone,
    output req_rdata, req_bdone, req_err, s_ss, s_we, s_addr, s_wdata
  );

  modport master (
    output req_ss, req_we, req_addr, req_wdata, s_rdata, s_bdone,
    input  req_rdata, req_bdone, req_err, s_ss, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/bus_rr_arbiter_rr_picker.sv
// Combinational round-robin search: first set request after last_i, wrapping modulo N.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Walk from farthest to nearest so the nearest requester after last_i overwrites.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % N]) begin
        idx_o = IW'((int'(last_i) + k) % N);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral slave among N_REQ masters (IDLE -> BUSY -> RESP).
// Optional ARB_TIMEOUT_EN: BUSY watchdog that completes with ARB_ERR_RDATA and an error pulse.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_rr_arbiter_if.slave bus
);

  localparam int IW = idx_w(N_REQ);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          tmo_hit;

  rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .req_i  (bus.req_ss),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != BUSY)     cnt_d = '0;
    else if (!bus.s_bdone)   cnt_d = cnt_q + 1'b1;
  end

  // Fires on the TIMEOUT-th BUSY cycle without a downstream done.
  assign tmo_hit = (state_q == BUSY) && !bus.s_bdone && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          we_d    = bus.req_we[pick_idx];
          addr_d  = bus.req_addr[pick_idx];
          wdata_d = bus.req_wdata[pick_idx];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.s_bdone) begin
          rdata_d = bus.s_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_hit) begin
          rdata_d = DW'(ARB_ERR_RDATA);
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.s_ss    = (state_q == BUSY);
  assign bus.s_we    = we_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;

  // Response is steered to the granted lane only; other lanes see zero.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    logic sel;
    assign sel              = (state_q == RESP) && (grant_q == IW'(i));
    assign bus.req_bdone[i] = sel;
    assign bus.req_err[i]   = sel & err_q;
    assign bus.req_rdata[i] = sel ? rdata_q : '0;
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter; timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_bus_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   errs = 0;
  int   checks = 0;

  bus_rr_arbiter_if #(.N_REQ(2), .AW(32), .DW(32)) ifc ();

  bus_rr_arbiter #(.N_REQ(2), .AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Slave model: done after sl_lat extra cycles of s_ss, or never.
  int          sl_cnt = 0;
  int          sl_lat = 0;
  bit          sl_never = 1'b0;
  logic [31:0] sl_rdata = '0;

  always @(posedge clk) begin
    if (!ifc.s_ss || ifc.s_bdone) sl_cnt <= 0;
    else                          sl_cnt <= sl_cnt + 1;
  end

  assign ifc.s_bdone = ifc.s_ss && !sl_never && (sl_cnt == sl_lat);
  assign ifc.s_rdata = sl_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.req_ss = '0;
    ifc.req_we = '0;
    ifc.req_addr = '0;
    ifc.req_wdata = '0;
    sl_lat = 0;
    sl_never = 1'b0;
    sl_rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ifc.s_ss !== 1'b0) begin errs++; $display("FAIL reset_s_ss got=%b want=0", ifc.s_ss); end
    checks++; if (ifc.req_bdone !== 2'b00) begin errs++; $display("FAIL reset_bdone got=%b want=00", ifc.req_bdone); end
    checks++; if (ifc.req_rdata !== 64'h0) begin errs++; $display("FAIL reset_rdata got=%h want=0", ifc.req_rdata); end
    checks++; if (ifc.s_addr !== 32'h0 || ifc.s_wdata !== 32'h0 || ifc.s_we !== 1'b0) begin
      errs++; $display("FAIL reset_s_bus got addr=%h wdata=%h we=%b want 0", ifc.s_addr, ifc.s_wdata, ifc.s_we);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    sl_rdata = 32'h0000_00A5;
    ifc.req_ss[0] = 1'b1;
    ifc.req_we[0] = 1'b0;
    ifc.req_addr[0] = 32'h4;
    tick();
    checks++; if (ifc.s_ss !== 1'b1 || ifc.s_addr !== 32'h4 || ifc.s_we !== 1'b0) begin
      errs++; $display("FAIL read_busy got ss=%b addr=%h we=%b want 1/4/0", ifc.s_ss, ifc.s_addr, ifc.s_we);
    end
    checks++; if (ifc.req_bdone !== 2'b00) begin errs++; $display("FAIL read_early_bdone got=%b want=00", ifc.req_bdone); end
    tick();
    checks++; if (ifc.s_ss !== 1'b0) begin errs++; $display("FAIL read_ss_one_cycle got=%b want=0", ifc.s_ss); end
    checks++; if (ifc.req_bdone !== 2'b01) begin errs++; $display("FAIL read_bdone got=%b want=01", ifc.req_bdone); end
    checks++; if (ifc.req_rdata[0] !== 32'hA5 || ifc.req_rdata[1] !== 32'h0) begin
      errs++; $display("FAIL read_rdata got r0=%h r1=%h want a5/0", ifc.req_rdata[0], ifc.req_rdata[1]);
    end
    checks++; if (ifc.req_err !== 2'b00) begin errs++; $display("FAIL read_err got=%b want=00", ifc.req_err); end
    ifc.req_ss = '0;
    tick();
    checks++; if (ifc.req_bdone !== 2'b00) begin errs++; $display("FAIL read_bdone_pulse got=%b want=00", ifc.req_bdone); end
  endtask

  task automatic test_rotation();
    logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_wd  [4] = '{32'h1111, 32'h2222, 32'h1111, 32'h2222};
    logic [31:0] exp_ad  [4] = '{32'h10, 32'h20, 32'h10, 32'h20};
    do_reset();
    ifc.req_ss = 2'b11;
    ifc.req_we = 2'b11;
    ifc.req_addr[0] = 32'h10;  ifc.req_wdata[0] = 32'h1111;
    ifc.req_addr[1] = 32'h20;  ifc.req_wdata[1] = 32'h2222;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++; if (ifc.s_ss !== 1'b1 || ifc.s_we !== 1'b1 || ifc.s_wdata !== exp_wd[n] || ifc.s_addr !== exp_ad[n]) begin
        errs++; $display("FAIL rot_bus[%0d] got ss=%b we=%b addr=%h wdata=%h want 1/1/%h/%h",
                         n, ifc.s_ss, ifc.s_we, ifc.s_addr, ifc.s_wdata, exp_ad[n], exp_wd[n]);
      end
      tick();
      checks++; if (ifc.req_bdone !== exp_gnt[n]) begin
        errs++; $display("FAIL rot_bdone[%0d] got=%b want=%b", n, ifc.req_bdone, exp_gnt[n]);
      end
      tick();
    end
    ifc.req_ss = '0;
  endtask

  task automatic test_stall();
    int pulses = 0;
    do_reset();
    sl_lat = 5;
    ifc.req_ss[0] = 1'b1;
    ifc.req_we[0] = 1'b1;
    ifc.req_addr[0] = 32'h30;
    ifc.req_wdata[0] = 32'hCAFE;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ifc.req_bdone != 2'b00) pulses++;
      checks++; if (ifc.s_ss !== 1'b1 || ifc.s_addr !== 32'h30 || ifc.s_wdata !== 32'hCAFE) begin
        errs++; $display("FAIL stall_busy[%0d] got ss=%b addr=%h wdata=%h want 1/30/cafe", c, ifc.s_ss, ifc.s_addr, ifc.s_wdata);
      end
    end
    tick();
    checks++; if (ifc.s_ss !== 1'b0 || ifc.req_bdone !== 2'b01) begin
      errs++; $display("FAIL stall_done got ss=%b bdone=%b want 0/01", ifc.s_ss, ifc.req_bdone);
    end
    if (ifc.req_bdone != 2'b00) pulses++;
    ifc.req_ss = '0;
    tick();
    if (ifc.req_bdone != 2'b00) pulses++;
    checks++; if (pulses !== 1) begin errs++; $display("FAIL stall_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sl_lat = 3;
    ifc.req_addr[0] = 32'h40;
    ifc.req_addr[1] = 32'h44;
    ifc.req_ss = 2'b10;
    tick();
    checks++; if (ifc.s_ss !== 1'b1 || ifc.s_addr !== 32'h44) begin
      errs++; $display("FAIL rstmid_grant1 got ss=%b addr=%h want 1/44", ifc.s_ss, ifc.s_addr);
    end
    tick();
    ifc.req_ss = 2'b11;
    rst_n = 1'b0;
    tick();
    checks++; if (ifc.s_ss !== 1'b0 || ifc.req_bdone !== 2'b00) begin
      errs++; $display("FAIL rstmid_abort got ss=%b bdone=%b want 0/00", ifc.s_ss, ifc.req_bdone);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (ifc.s_ss !== 1'b1 || ifc.s_addr !== 32'h40 || ifc.req_bdone !== 2'b00) begin
      errs++; $display("FAIL rstmid_first_grant got ss=%b addr=%h bdone=%b want 1/40/00", ifc.s_ss, ifc.s_addr, ifc.req_bdone);
    end
    ifc.req_ss = '0;
  endtask

  task automatic test_drop_mid_busy();
    do_reset();
    sl_lat = 3;
    sl_rdata = 32'h0000_0077;
    ifc.req_we = 2'b10;
    ifc.req_addr[0] = 32'h50;
    ifc.req_addr[1] = 32'h60;
    ifc.req_wdata[1] = 32'h6666;
    ifc.req_ss = 2'b10;
    tick();
    ifc.req_ss = 2'b01;
    tick();
    tick();
    tick();
    checks++; if (ifc.s_ss !== 1'b1 || ifc.s_addr !== 32'h60 || ifc.s_wdata !== 32'h6666) begin
      errs++; $display("FAIL drop_still_busy got ss=%b addr=%h wdata=%h want 1/60/6666", ifc.s_ss, ifc.s_addr, ifc.s_wdata);
    end
    tick();
    checks++; if (ifc.req_bdone !== 2'b10 || ifc.req_rdata[1] !== 32'h77 || ifc.req_rdata[0] !== 32'h0) begin
      errs++; $display("FAIL drop_bdone got bdone=%b r1=%h r0=%h want 10/77/0", ifc.req_bdone, ifc.req_rdata[1], ifc.req_rdata[0]);
    end
    tick();
    tick();
    checks++; if (ifc.s_ss !== 1'b1 || ifc.s_addr !== 32'h50) begin
      errs++; $display("FAIL drop_next_grant got ss=%b addr=%h want 1/50", ifc.s_ss, ifc.s_addr);
    end
    ifc.req_ss = '0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    sl_never = 1'b1;
    ifc.req_ss[0] = 1'b1;
    ifc.req_addr[0] = 32'h8;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (ifc.s_ss !== 1'b1 || ifc.req_bdone !== 2'b00) begin
        errs++; $display("FAIL tmo_busy[%0d] got ss=%b bdone=%b want 1/00", c, ifc.s_ss, ifc.req_bdone);
      end
    end
    tick();
    checks++; if (ifc.req_bdone !== 2'b01 || ifc.req_err !== 2'b01 || ifc.req_rdata[0] !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL tmo_resp got bdone=%b err=%b rdata=%h want 01/01/deadbeef", ifc.req_bdone, ifc.req_err, ifc.req_rdata[0]);
    end
    ifc.req_ss = '0;
    tick();
    checks++; if (ifc.req_err !== 2'b00) begin errs++; $display("FAIL tmo_err_pulse got=%b want=00", ifc.req_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_rotation();
    test_stall();
    test_reset_mid();
    test_drop_mid_busy();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
